permute_issue: RTL and testbench

- Issue/operand-fetch stage that drives the odd-pipe Permute unit, i.e. the initiator side of its RF/FWD interface.
- Accepts raw 32-bit SPU instruction words and decodes the quadword shift/rotate subset.
- Reads a 128x128 register file, which is written back from Permute's WB outputs.
- Stalls the instruction source on RAW hazards against results still in flight in the Permute pipe.

---
 rtl/permute_issue.sv | 191 +++++++++++++++++++
 tb/tb_permute_issue.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/permute_issue.sv
// permute_issue
// Issue / operand-fetch stage for the odd-pipe Permute unit. Accepts raw
// 32-bit SPU instruction words, decodes the quadword shift/rotate subset,
// reads operands from a 128 x 128-bit register file (written back from the
// Permute WB port) and stalls the instruction source on RAW hazards against
// results still travelling through the Permute pipe.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   instr, instr_valid    instruction word offered by the source
//   instr_ready           word accepted on an edge where valid && ready
//   op, format, rt_addr   registered decoded instruction to Permute
//   ra, rb, imm           registered operands (rb only for RR, imm only for RI7)
//   reg_write             registered: the issued instruction writes RT
//   rt_wb, rt_addr_wb,
//   reg_write_wb          Permute writeback into the register file
//   illegal_op            one-cycle pulse after an unsupported word is accepted
//   stall_count           saturating count of cycles the source was stalled
module permute_issue #(
   parameter int PIPE_DEPTH = 3,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [0:31]      instr,
   input  logic             instr_valid,
   output logic             instr_ready,
   output logic [0:10]      op,
   output logic [2:0]       format,
   output logic [0:6]       rt_addr,
   output logic [0:127]     ra,
   output logic [0:127]     rb,
   output logic [0:17]      imm,
   output logic             reg_write,
   input  logic [0:127]     rt_wb,
   input  logic [0:6]       rt_addr_wb,
   input  logic             reg_write_wb,
   output logic             illegal_op,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [0:10] OP_SHLQBI  = 11'b00111011011;
   localparam logic [0:10] OP_SHLQBY  = 11'b00111011111;
   localparam logic [0:10] OP_ROTQBI  = 11'b00111011000;
   localparam logic [0:10] OP_ROTQBY  = 11'b00111011100;
   localparam logic [0:10] OP_SHLQBII = 11'b00111111011;
   localparam logic [0:10] OP_SHLQBYI = 11'b00111111111;
   localparam logic [0:10] OP_ROTQBII = 11'b00111111000;
   localparam logic [0:10] OP_ROTQBYI = 11'b00111111100;
   localparam logic [0:10] OP_LNOP    = 11'b00000000001;

   // Instruction fields
   logic [0:10] opc;
   logic [0:6]  f_rb;    // RB for RR, I7 for RI7
   logic [0:6]  f_ra;
   logic [0:6]  f_rt;

   assign opc  = instr[0:10];
   assign f_rb = instr[11:17];
   assign f_ra = instr[18:24];
   assign f_rt = instr[25:31];

   logic is_rr;
   logic is_ri7;
   logic is_legal;
   logic is_illegal;

   always_comb begin
      is_rr  = 1'b0;
      is_ri7 = 1'b0;
      case (opc)
         OP_SHLQBI, OP_SHLQBY, OP_ROTQBI, OP_ROTQBY:     is_rr  = 1'b1;
         OP_SHLQBII, OP_SHLQBYI, OP_ROTQBII, OP_ROTQBYI: is_ri7 = 1'b1;
         default: ;
      endcase
   end

   assign is_legal   = is_rr | is_ri7;
   assign is_illegal = !is_legal && (opc != OP_LNOP);

   // Register file and write-first operand read
   logic [0:127] rf_mem [128];
   logic [0:127] ra_val;
   logic [0:127] rb_val;

   assign ra_val = (reg_write_wb && (rt_addr_wb == f_ra)) ? rt_wb : rf_mem[f_ra];
   assign rb_val = (reg_write_wb && (rt_addr_wb == f_rb)) ? rt_wb : rf_mem[f_rb];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 128; i++) begin
            rf_mem[i] <= '0;
         end
      end else if (reg_write_wb) begin
         rf_mem[rt_addr_wb] <= rt_wb;
      end
   end

   // Scoreboard of destinations in flight; entry 0 is the instruction
   // currently on the Permute inputs.
   logic [PIPE_DEPTH-1:0] sb_valid_reg;
   logic [0:6]            sb_addr_reg [PIPE_DEPTH];
   logic [PIPE_DEPTH-1:0] entry_hit;
   logic                  oldest_on_wb;
   logic                  hazard;
   logic                  accept;
   logic                  issue;

   // The oldest entry's result is on the WB bus in this cycle; if it is
   // really there, the bypass supplies the operand and the entry no longer
   // needs to block.
   assign oldest_on_wb = reg_write_wb && (rt_addr_wb == sb_addr_reg[PIPE_DEPTH-1]);

   generate
      for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_hit
         logic src_match;
         assign src_match = (sb_addr_reg[gi] == f_ra) || (is_rr && (sb_addr_reg[gi] == f_rb));
         if (gi == PIPE_DEPTH - 1) begin : g_oldest
            assign entry_hit[gi] = sb_valid_reg[gi] && src_match && !oldest_on_wb;
         end else begin : g_young
            assign entry_hit[gi] = sb_valid_reg[gi] && src_match;
         end
      end
   endgenerate

   // lnop and illegal words have no sources, so they never stall.
   assign hazard      = is_legal && (|entry_hit);
   assign instr_ready = !hazard;
   assign accept      = instr_valid && instr_ready;
   assign issue       = accept && is_legal;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sb_valid_reg <= '0;
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            sb_addr_reg[i] <= '0;
         end
      end else begin
         sb_valid_reg[0] <= issue;
         sb_addr_reg[0]  <= issue ? f_rt : 7'd0;
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            sb_valid_reg[i] <= sb_valid_reg[i-1];
            sb_addr_reg[i]  <= sb_addr_reg[i-1];
         end
      end
   end

   // Registered outputs: Permute cannot stall, so every cycle without an
   // issue presents a bubble rather than holding the previous instruction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op         <= '0;
         format     <= '0;
         rt_addr    <= '0;
         ra         <= '0;
         rb         <= '0;
         imm        <= '0;
         reg_write  <= 1'b0;
         illegal_op <= 1'b0;
      end else begin
         illegal_op <= accept && is_illegal;
         if (issue) begin
            op        <= opc;
            format    <= is_ri7 ? 3'b001 : 3'b000;
            rt_addr   <= f_rt;
            ra        <= ra_val;
            rb        <= is_rr ? rb_val : '0;
            imm       <= is_ri7 ? {11'd0, f_rb} : 18'd0;
            reg_write <= 1'b1;
         end else begin
            op        <= '0;
            format    <= '0;
            rt_addr   <= '0;
            ra        <= '0;
            rb        <= '0;
            imm       <= '0;
            reg_write <= 1'b0;
         end
      end
   end

   // Stall counter, saturating at all-ones
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_count <= '0;
      end else if (instr_valid && !instr_ready && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_permute_issue.sv
// tb_permute_issue
// Directed scenarios plus a randomized run against a behavioural model of
// the issue stage. The model tracks, per register, the cycle in which the
// newest in-flight result reaches the WB bus; a word may issue once every
// source is either settled in the register file or on the WB bus.
// The bench plays the Permute unit: every issued instruction returns its
// result on WB three cycles after acceptance (two cycles after it appears
// on the Permute inputs).
module tb_permute_issue;

   localparam int PD = 3;
   localparam int CW = 4;   // narrow counter so saturation is reachable
   localparam int RN = 400;

   localparam logic [10:0] SHLQBI  = 11'b00111011011;
   localparam logic [10:0] SHLQBY  = 11'b00111011111;
   localparam logic [10:0] ROTQBI  = 11'b00111011000;
   localparam logic [10:0] ROTQBY  = 11'b00111011100;
   localparam logic [10:0] SHLQBII = 11'b00111111011;
   localparam logic [10:0] SHLQBYI = 11'b00111111111;
   localparam logic [10:0] ROTQBII = 11'b00111111000;
   localparam logic [10:0] ROTQBYI = 11'b00111111100;
   localparam logic [10:0] LNOP    = 11'b00000000001;
   localparam logic [10:0] BADOP   = 11'b01010110100;
   localparam logic [10:0] RR_TAB [4] = '{SHLQBI, SHLQBY, ROTQBI, ROTQBY};
   localparam logic [10:0] RI_TAB [4] = '{SHLQBII, SHLQBYI, ROTQBII, ROTQBYI};
   localparam logic [127:0] R1_VAL = 128'h00101131337377F7FF000000000000FF;

   logic           clk = 1'b0;
   logic           reset;
   logic [0:31]    instr;
   logic           instr_valid;
   logic           instr_ready;
   logic [0:10]    op;
   logic [2:0]     format;
   logic [0:6]     rt_addr;
   logic [0:127]   ra;
   logic [0:127]   rb;
   logic [0:17]    imm;
   logic           reg_write;
   logic [0:127]   rt_wb;
   logic [0:6]     rt_addr_wb;
   logic           reg_write_wb;
   logic           illegal_op;
   logic [CW-1:0]  stall_count;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   permute_issue #(.PIPE_DEPTH(PD), .CNT_W(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .op           (op),
      .format       (format),
      .rt_addr      (rt_addr),
      .ra           (ra),
      .rb           (rb),
      .imm          (imm),
      .reg_write    (reg_write),
      .rt_wb        (rt_wb),
      .rt_addr_wb   (rt_addr_wb),
      .reg_write_wb (reg_write_wb),
      .illegal_op   (illegal_op),
      .stall_count  (stall_count)
   );

   function automatic logic [31:0] mk(input logic [10:0] o, input logic [6:0] b,
                                      input logic [6:0] a, input logic [6:0] t);
      return {o, b, a, t};
   endfunction

   function automatic logic is_rr_op(input logic [10:0] o);
      for (int i = 0; i < 4; i++) if (RR_TAB[i] == o) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic is_ri_op(input logic [10:0] o);
      for (int i = 0; i < 4; i++) if (RI_TAB[i] == o) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Stimulus helpers (no checking); all return at posedge + 1.
   task automatic idle(input int n);
      instr_valid  = 1'b0;
      instr        = mk(LNOP, 7'd0, 7'd0, 7'd0);
      reg_write_wb = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wb_load(input logic [6:0] a, input logic [127:0] v);
      rt_addr_wb = a; rt_wb = v; reg_write_wb = 1'b1;
      @(posedge clk); #1;
      reg_write_wb = 1'b0;
   endtask

   task automatic pulse_reset;
      idle(0);
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b0; instr = 32'd0; instr_valid = 1'b0;
      rt_wb = '0; rt_addr_wb = '0; reg_write_wb = 1'b0;
      @(negedge clk);
      n_checks++; if (op !== 11'd0) $display("FAIL reset_op got %h want 0", op); else n_pass++;
      n_checks++; if (format !== 3'd0) $display("FAIL reset_format got %h want 0", format); else n_pass++;
      n_checks++; if (rt_addr !== 7'd0) $display("FAIL reset_rt got %h want 0", rt_addr); else n_pass++;
      n_checks++; if (ra !== 128'd0) $display("FAIL reset_ra got %h want 0", ra); else n_pass++;
      n_checks++; if (rb !== 128'd0) $display("FAIL reset_rb got %h want 0", rb); else n_pass++;
      n_checks++; if (imm !== 18'd0) $display("FAIL reset_imm got %h want 0", imm); else n_pass++;
      n_checks++; if (reg_write !== 1'b0) $display("FAIL reset_rw got %b want 0", reg_write); else n_pass++;
      n_checks++; if (illegal_op !== 1'b0) $display("FAIL reset_ill got %b want 0", illegal_op); else n_pass++;
      n_checks++; if (stall_count !== 4'd0) $display("FAIL reset_stall got %0d want 0", stall_count); else n_pass++;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      n_checks++; if (instr_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", instr_ready); else n_pass++;
      $display("reset: released");
      @(posedge clk); #1;
   endtask

   task automatic test_rr;
      wb_load(7'd1, R1_VAL);
      wb_load(7'd2, 128'd2);
      instr = mk(SHLQBI, 7'd2, 7'd1, 7'd3); instr_valid = 1'b1;
      @(negedge clk);
      n_checks++; if (instr_ready !== 1'b1) $display("FAIL rr_ready got %b want 1", instr_ready); else n_pass++;
      @(posedge clk); #1;
      instr_valid = 1'b0; instr = mk(LNOP, 7'd0, 7'd0, 7'd0);
      @(negedge clk);
      $display("issue shlqbi rt=3 ra=1 rb=2: op=%b ra=%h rb=%h", op, ra, rb);
      n_checks++; if (op !== SHLQBI) $display("FAIL rr_op got %b want %b", op, SHLQBI); else n_pass++;
      n_checks++; if (format !== 3'b000) $display("FAIL rr_format got %b want 000", format); else n_pass++;
      n_checks++; if (rt_addr !== 7'd3) $display("FAIL rr_rt got %0d want 3", rt_addr); else n_pass++;
      n_checks++; if (ra !== R1_VAL) $display("FAIL rr_ra got %h want %h", ra, R1_VAL); else n_pass++;
      n_checks++; if (rb !== 128'd2) $display("FAIL rr_rb got %h want 2", rb); else n_pass++;
      n_checks++; if (imm !== 18'd0) $display("FAIL rr_imm got %h want 0", imm); else n_pass++;
      n_checks++; if (reg_write !== 1'b1) $display("FAIL rr_rw got %b want 1", reg_write); else n_pass++;
      n_checks++; if (instr_ready !== 1'b1) $display("FAIL rr_ready2 got %b want 1", instr_ready); else n_pass++;
      @(negedge clk);
      n_checks++; if (op !== 11'd0 || reg_write !== 1'b0)
         $display("FAIL rr_one_cycle got op=%b rw=%b want bubble", op, reg_write); else n_pass++;
      @(posedge clk); #1;
      idle(4);
   endtask

   task automatic test_ri7;
      instr = mk(ROTQBYI, 7'd5, 7'd1, 7'd4); instr_valid = 1'b1;
      @(negedge clk);
      n_checks++; if (instr_ready !== 1'b1) $display("FAIL ri_ready got %b want 1", instr_ready); else n_pass++;
      @(posedge clk); #1;
      idle(0);
      @(negedge clk);
      $display("issue rotqbyi rt=4 ra=1 i7=5: format=%b imm=%h", format, imm);
      n_checks++; if (op !== ROTQBYI) $display("FAIL ri_op got %b want %b", op, ROTQBYI); else n_pass++;
      n_checks++; if (format !== 3'b001) $display("FAIL ri_format got %b want 001", format); else n_pass++;
      n_checks++; if (imm !== 18'h00005) $display("FAIL ri_imm got %h want 00005", imm); else n_pass++;
      n_checks++; if (rb !== 128'd0) $display("FAIL ri_rb got %h want 0", rb); else n_pass++;
      n_checks++; if (ra !== R1_VAL) $display("FAIL ri_ra got %h want %h", ra, R1_VAL); else n_pass++;
      n_checks++; if (rt_addr !== 7'd4) $display("FAIL ri_rt got %0d want 4", rt_addr); else n_pass++;
      @(posedge clk); #1;
      idle(4);
   endtask

   task automatic test_raw;
      logic [127:0] v;
      v = rand128();
      instr = mk(SHLQBI, 7'd2, 7'd1, 7'd3); instr_valid = 1'b1;
      @(negedge clk);
      n_checks++; if (instr_ready !== 1'b1) $display("FAIL raw_prod_ready got %b want 1", instr_ready); else n_pass++;
      @(posedge clk); #1;
      instr = mk(ROTQBII, 7'd0, 7'd3, 7'd5);
      @(negedge clk);
      n_checks++; if (instr_ready !== 1'b0) $display("FAIL raw_stall1 got %b want 0", instr_ready); else n_pass++;
      n_checks++; if (op !== SHLQBI) $display("FAIL raw_prod_op got %b want %b", op, SHLQBI); else n_pass++;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++; if (instr_ready !== 1'b0) $display("FAIL raw_stall2 got %b want 0", instr_ready); else n_pass++;
      n_checks++; if (op !== 11'd0 || reg_write !== 1'b0)
         $display("FAIL raw_bubble got op=%b rw=%b want bubble", op, reg_write); else n_pass++;
      n_checks++; if (stall_count !== 4'd1) $display("FAIL raw_cnt1 got %0d want 1", stall_count); else n_pass++;
      @(posedge clk); #1;
      rt_addr_wb = 7'd3; rt_wb = v; reg_write_wb = 1'b1;
      @(negedge clk);
      n_checks++; if (instr_ready !== 1'b1) $display("FAIL raw_release got %b want 1", instr_ready); else n_pass++;
      n_checks++; if (stall_count !== 4'd2) $display("FAIL raw_cnt2 got %0d want 2", stall_count); else n_pass++;
      @(posedge clk); #1;
      idle(0);
      @(negedge clk);
      $display("raw dependent rotqbii rt=5 ra=3: ra=%h", ra);
      n_checks++; if (op !== ROTQBII) $display("FAIL raw_dep_op got %b want %b", op, ROTQBII); else n_pass++;
      n_checks++; if (ra !== v) $display("FAIL raw_fwd got %h want %h", ra, v); else n_pass++;
      n_checks++; if (stall_count !== 4'd2) $display("FAIL raw_cnt_hold got %0d want 2", stall_count); else n_pass++;
      @(posedge clk); #1;
      idle(4);
      // r3 now holds the written-back value
      instr = mk(SHLQBII, 7'd0, 7'd3, 7'd9); instr_valid = 1'b1;
      @(posedge clk); #1;
      idle(0);
      @(negedge clk);
      n_checks++; if (ra !== v) $display("FAIL raw_rf3 got %h want %h", ra, v); else n_pass++;
      @(posedge clk); #1;
      idle(4);
   endtask

   task automatic test_bypass;
      logic [127:0] v;
      v = ~128'd1;
      rt_addr_wb = 7'd7; rt_wb = v; reg_write_wb = 1'b1;
      instr = mk(SHLQBII, 7'd1, 7'd7, 7'd8); instr_valid = 1'b1;
      @(negedge clk);
      n_checks++; if (instr_ready !== 1'b1) $display("FAIL byp_ready got %b want 1", instr_ready); else n_pass++;
      @(posedge clk); #1;
      idle(0);
      @(negedge clk);
      $display("bypass shlqbii ra=7 with same-cycle WB: ra=%h", ra);
      n_checks++; if (ra !== v) $display("FAIL byp_ra got %h want %h", ra, v); else n_pass++;
      n_checks++; if (imm !== 18'd1) $display("FAIL byp_imm got %h want 1", imm); else n_pass++;
      @(posedge clk); #1;
      instr = mk(ROTQBI, 7'd7, 7'd7, 7'd10); instr_valid = 1'b1;
      @(posedge clk); #1;
      idle(0);
      @(negedge clk);
      n_checks++; if (ra !== v) $display("FAIL byp_rf7_ra got %h want %h", ra, v); else n_pass++;
      n_checks++; if (rb !== v) $display("FAIL byp_rf7_rb got %h want %h", rb, v); else n_pass++;
      @(posedge clk); #1;
      idle(4);
   endtask

   task automatic test_illegal;
      instr = mk(SHLQBI, 7'd2, 7'd1, 7'd3); instr_valid = 1'b1;
      @(posedge clk); #1;
      instr = mk(BADOP, 7'd3, 7'd3, 7'd3);
      @(negedge clk);
      n_checks++; if (instr_ready !== 1'b1) $display("FAIL ill_ready got %b want 1", instr_ready); else n_pass++;
      @(posedge clk); #1;
      instr = mk(LNOP, 7'd3, 7'd3, 7'd3);
      @(negedge clk);
      $display("illegal word accepted: illegal_op=%b op=%b", illegal_op, op);
      n_checks++; if (illegal_op !== 1'b1) $display("FAIL ill_pulse got %b want 1", illegal_op); else n_pass++;
      n_checks++; if (op !== 11'd0 || reg_write !== 1'b0 || ra !== 128'd0)
         $display("FAIL ill_bubble got op=%b rw=%b want bubble", op, reg_write); else n_pass++;
      n_checks++; if (instr_ready !== 1'b1) $display("FAIL lnop_ready got %b want 1", instr_ready); else n_pass++;
      @(posedge clk); #1;
      idle(0);
      @(negedge clk);
      n_checks++; if (illegal_op !== 1'b0) $display("FAIL ill_one_cycle got %b want 0", illegal_op); else n_pass++;
      n_checks++; if (stall_count !== 4'd2) $display("FAIL ill_cnt got %0d want 2", stall_count); else n_pass++;
      @(posedge clk); #1;
      idle(4);
   endtask

   task automatic test_reset_mid;
      logic [127:0] w;
      w = rand128();
      instr = mk(SHLQBI, 7'd2, 7'd1, 7'd3); instr_valid = 1'b1;
      @(posedge clk); #1;
      instr = mk(ROTQBII, 7'd0, 7'd3, 7'd5);
      @(negedge clk);
      n_checks++; if (instr_ready !== 1'b0) $display("FAIL rmid_stall got %b want 0", instr_ready); else n_pass++;
      n_checks++; if (op !== SHLQBI) $display("FAIL rmid_pre_op got %b want %b", op, SHLQBI); else n_pass++;
      #2 reset = 1'b0;
      #1;
      n_checks++; if (op !== 11'd0 || reg_write !== 1'b0 || ra !== 128'd0 || rb !== 128'd0)
         $display("FAIL rmid_async_out got op=%b rw=%b want 0", op, reg_write); else n_pass++;
      n_checks++; if (stall_count !== 4'd0) $display("FAIL rmid_async_cnt got %0d want 0", stall_count); else n_pass++;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      n_checks++; if (instr_ready !== 1'b1) $display("FAIL rmid_ready got %b want 1", instr_ready); else n_pass++;
      @(posedge clk); #1;
      idle(0);
      @(negedge clk);
      $display("after mid-stall reset: op=%b ra=%h", op, ra);
      n_checks++; if (op !== ROTQBII) $display("FAIL rmid_dep_op got %b want %b", op, ROTQBII); else n_pass++;
      n_checks++; if (ra !== 128'd0) $display("FAIL rmid_rf3 got %h want 0", ra); else n_pass++;
      n_checks++; if (stall_count !== 4'd0) $display("FAIL rmid_cnt got %0d want 0", stall_count); else n_pass++;
      @(posedge clk); #1;
      wb_load(7'd9, w);
      instr = mk(ROTQBI, 7'd1, 7'd9, 7'd12); instr_valid = 1'b1;
      @(posedge clk); #1;
      idle(0);
      @(negedge clk);
      n_checks++; if (ra !== w) $display("FAIL rmid_wb9 got %h want %h", ra, w); else n_pass++;
      n_checks++; if (rb !== 128'd0) $display("FAIL rmid_rf1 got %h want 0", rb); else n_pass++;
      @(posedge clk); #1;
      idle(4);
   endtask

   task automatic test_saturate;
      int e;
      pulse_reset();
      for (int p = 1; p <= 8; p++) begin
         instr = mk(SHLQBI, 7'd2, 7'd1, 7'd3); instr_valid = 1'b1;
         @(posedge clk); #1;
         instr = mk(ROTQBII, 7'd0, 7'd3, 7'd5);
         repeat (2) begin @(posedge clk); #1; end
         rt_addr_wb = 7'd3; rt_wb = rand128(); reg_write_wb = 1'b1;
         @(posedge clk); #1;
         idle(0);
         e = (2 * p > 15) ? 15 : 2 * p;
         @(negedge clk);
         $display("saturate pair %0d: stall_count=%0d", p, stall_count);
         n_checks++; if (stall_count !== 4'(e)) $display("FAIL sat_cnt_%0d got %0d want %0d", p, stall_count, e); else n_pass++;
         @(posedge clk); #1;
      end
      idle(4);
   endtask

   task automatic test_random;
      int           busy_until [128];
      logic [127:0] rf_m [128];
      logic         wbv [RN+8];
      logic [6:0]   wba [RN+8];
      logic [127:0] wbd [RN+8];
      logic [10:0]  e_op, o;
      logic [2:0]   e_fmt;
      logic [6:0]   e_rt, fa, fb, ft;
      logic [127:0] e_ra, e_rb, va, vb;
      logic [17:0]  e_imm;
      logic         e_rw, e_ill, hold, rr, ri, legal, exp_ready, acc;
      int           e_stall, c;
      pulse_reset();
      for (int i = 0; i < 128; i++) begin busy_until[i] = -1; rf_m[i] = '0; end
      for (int i = 0; i < RN + 8; i++) begin wbv[i] = 1'b0; wba[i] = '0; wbd[i] = '0; end
      e_op = '0; e_fmt = '0; e_rt = '0; e_ra = '0; e_rb = '0; e_imm = '0;
      e_rw = 1'b0; e_ill = 1'b0; e_stall = 0; hold = 1'b0;
      o = LNOP; fa = '0; fb = '0; ft = '0;
      for (int k = 0; k < RN; k++) begin
         if (!hold) begin
            instr_valid = ($urandom_range(0, 4) != 0);
            c = $urandom_range(0, 9);
            if (c < 4)       o = RR_TAB[$urandom_range(0, 3)];
            else if (c < 8)  o = RI_TAB[$urandom_range(0, 3)];
            else if (c == 8) o = LNOP;
            else begin
               o = 11'($urandom());
               while (is_rr_op(o) || is_ri_op(o) || o == LNOP) o = 11'($urandom());
            end
            fa = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 7));
            fb = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 7));
            ft = 7'($urandom_range(0, 7));
            instr = mk(o, fb, fa, ft);
         end
         reg_write_wb = wbv[k]; rt_addr_wb = wba[k]; rt_wb = wbd[k];
         rr = is_rr_op(o); ri = is_ri_op(o); legal = rr | ri;
         exp_ready = !legal || !((busy_until[fa] > k) || (rr && busy_until[fb] > k));
         @(negedge clk);
         n_checks++; if (instr_ready !== exp_ready) $display("FAIL rnd_ready cyc %0d got %b want %b", k, instr_ready, exp_ready); else n_pass++;
         n_checks++; if (op !== e_op) $display("FAIL rnd_op cyc %0d got %b want %b", k, op, e_op); else n_pass++;
         n_checks++; if (format !== e_fmt) $display("FAIL rnd_format cyc %0d got %b want %b", k, format, e_fmt); else n_pass++;
         n_checks++; if (rt_addr !== e_rt) $display("FAIL rnd_rt cyc %0d got %0d want %0d", k, rt_addr, e_rt); else n_pass++;
         n_checks++; if (ra !== e_ra) $display("FAIL rnd_ra cyc %0d got %h want %h", k, ra, e_ra); else n_pass++;
         n_checks++; if (rb !== e_rb) $display("FAIL rnd_rb cyc %0d got %h want %h", k, rb, e_rb); else n_pass++;
         n_checks++; if (imm !== e_imm) $display("FAIL rnd_imm cyc %0d got %h want %h", k, imm, e_imm); else n_pass++;
         n_checks++; if (reg_write !== e_rw) $display("FAIL rnd_rw cyc %0d got %b want %b", k, reg_write, e_rw); else n_pass++;
         n_checks++; if (illegal_op !== e_ill) $display("FAIL rnd_ill cyc %0d got %b want %b", k, illegal_op, e_ill); else n_pass++;
         n_checks++; if (stall_count !== 4'(e_stall)) $display("FAIL rnd_stall cyc %0d got %0d want %0d", k, stall_count, e_stall); else n_pass++;
         acc = instr_valid && exp_ready;
         va = (wbv[k] && wba[k] == fa) ? wbd[k] : rf_m[fa];
         vb = (wbv[k] && wba[k] == fb) ? wbd[k] : rf_m[fb];
         if (acc && legal) begin
            e_op = o; e_fmt = ri ? 3'b001 : 3'b000; e_rt = ft; e_ra = va;
            e_rb = rr ? vb : '0; e_imm = ri ? {11'd0, fb} : '0; e_rw = 1'b1;
            busy_until[ft] = k + 3;
            wbv[k+3] = 1'b1; wba[k+3] = ft; wbd[k+3] = rand128();
            $display("rand cyc %0d issue op=%b rt=%0d ra=%0d rb/i7=%0d", k, o, ft, fa, fb);
         end else begin
            e_op = '0; e_fmt = '0; e_rt = '0; e_ra = '0; e_rb = '0; e_imm = '0; e_rw = 1'b0;
         end
         e_ill = acc && !legal && (o != LNOP);
         if (instr_valid && !exp_ready && e_stall < 15) e_stall++;
         if (wbv[k]) rf_m[wba[k]] = wbd[k];
         hold = instr_valid && !exp_ready;
         @(posedge clk); #1;
      end
      idle(4);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_rr();
      test_ri7();
      test_raw();
      test_bypass();
      test_illegal();
      test_reset_mid();
      test_saturate();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
